// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter family: coefficient-count helper,
// coefficient loader state encoding and default word formats.
package iir_pkg;

    localparam int COEFW_DEF = 18;
    localparam int COEFQ_DEF = 16;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } ldr_state_t;

    function automatic int iir_ncoef(input int order);
        return (order + 1) * 2;
    endfunction

endpackage

// File: rtl/iir_coef_loader_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow slot, so the
// upstream ready is a register and never combinationally depends on i_ready.
module iir_coef_loader_skid #(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready
);

    logic              r_rdy;
    logic              r_ovld;
    logic              r_svld;
    logic [DATA_W-1:0] r_odata;
    logic [DATA_W-1:0] r_sdata;
    logic              w_in_acc;
    logic              w_out_free;

    assign w_in_acc   = i_valid & r_rdy;
    assign w_out_free = ~r_ovld | i_ready;
    assign o_ready    = r_rdy;
    assign o_valid    = r_ovld;
    assign o_data     = r_odata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy  <= 1'b0;
            r_ovld <= 1'b0;
            r_svld <= 1'b0;
        end else if (w_out_free) begin
            r_ovld <= r_svld | w_in_acc;
            r_svld <= 1'b0;
            r_rdy  <= 1'b1;
        end else if (w_in_acc) begin
            // output stalled: park the word and drop ready until it drains
            r_svld <= 1'b1;
            r_rdy  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_out_free) begin
            r_odata <= r_svld ? r_sdata : i_data;
        end
        if (!w_out_free && w_in_acc) begin
            r_sdata <= i_data;
        end
    end

endmodule

// File: rtl/iir_coef_loader.sv
// Coefficient loader for iir_core: assembles a set from an AXI-stream into shadow
// registers and swaps it in atomically on swap_ok. Optional readback: IIR_COEF_LOADER_READBACK_EN.
module iir_coef_loader
    import iir_pkg::*;
#(
    parameter  int COEFW     = COEFW_DEF,
    parameter  int ORDER     = 2,
    parameter  int RST_COEF0 = 1 << 16,
    localparam int N         = iir_ncoef(ORDER)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [COEFW-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    swap_ok,
    output logic signed [COEFW-1:0] coefs [N],
    output logic                    coef_update,
    output logic                    frame_err,
`ifdef IIR_COEF_LOADER_READBACK_EN
    input  logic                    rb_req,
    output logic        [COEFW-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
`endif
    input  logic                    err_clr
);

    localparam int IDXW = $clog2(N);

    ldr_state_t              r_state;
    logic [IDXW-1:0]         r_wr_idx;
    logic signed [COEFW-1:0] r_shadow [N];

    logic [COEFW:0]          w_sk_data;
    logic                    w_sk_vld;
    logic                    w_sk_rdy;
    logic                    w_sk_in_rdy;
    logic                    w_acc;
    logic                    w_last;
    logic                    w_idx_full;
    logic                    w_err;
    logic                    w_rb_hold;
    logic signed [COEFW-1:0] w_word;

    // the FSM refuses both the skid output and new upstream words while a set is pending
    assign w_sk_rdy      = (r_state != PENDING);
    assign s_axis_tready = w_sk_in_rdy & w_sk_rdy;

    iir_coef_loader_skid #(
        .DATA_W (COEFW + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({s_axis_tlast, s_axis_tdata}),
        .i_valid (s_axis_tvalid & w_sk_rdy),
        .o_ready (w_sk_in_rdy),
        .o_data  (w_sk_data),
        .o_valid (w_sk_vld),
        .i_ready (w_sk_rdy)
    );

    assign w_acc      = w_sk_vld & w_sk_rdy;
    assign w_last     = w_sk_data[COEFW];
    assign w_word     = w_sk_data[COEFW-1:0];
    assign w_idx_full = (r_wr_idx == IDXW'(N - 1));
    assign w_err      = w_acc && (r_state == FILL) && (w_last ? !w_idx_full : w_idx_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FILL;
            r_wr_idx    <= '0;
            coef_update <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
                coefs[i]    <= (i == 0) ? COEFW'(RST_COEF0) : '0;
            end
        end else begin
            coef_update <= 1'b0;
            if (w_err) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            case (r_state)
                FILL: begin
                    if (w_acc) begin
                        r_shadow[r_wr_idx] <= w_word;
                        if (w_last) begin
                            r_wr_idx <= '0;
                            if (w_idx_full) begin
                                r_state <= PENDING;
                            end
                        end else if (w_idx_full) begin
                            r_wr_idx <= '0;
                            r_state  <= DRAIN;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDXW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_acc && w_last) begin
                        r_state <= FILL;
                    end
                end
                PENDING: begin
                    if (swap_ok && !w_rb_hold) begin
                        coefs       <= r_shadow;
                        coef_update <= 1'b1;
                        r_state     <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

`ifdef IIR_COEF_LOADER_READBACK_EN
    logic            r_rb_busy;
    logic [IDXW-1:0] r_rb_idx;

    // a request in the same cycle also holds the swap so word 0 matches the set streamed
    assign w_rb_hold = r_rb_busy | rb_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb_busy     <= 1'b0;
            r_rb_idx      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (!r_rb_busy) begin
            if (rb_req) begin
                r_rb_busy     <= 1'b1;
                r_rb_idx      <= '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= coefs[0];
                m_axis_tlast  <= (N == 1);
            end
        end else if (m_axis_tready) begin
            if (r_rb_idx == IDXW'(N - 1)) begin
                r_rb_busy     <= 1'b0;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end else begin
                r_rb_idx      <= r_rb_idx + IDXW'(1);
                m_axis_tdata  <= coefs[r_rb_idx + IDXW'(1)];
                m_axis_tlast  <= (r_rb_idx == IDXW'(N - 2));
            end
        end
    end
`else
    assign w_rb_hold = 1'b0;
`endif

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed bench for iir_coef_loader (ORDER=2, N=6, COEFW=18).
module tb_iir_coef_loader;

    localparam int COEFW = 18;
    localparam int N     = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [COEFW-1:0] s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic                    s_tlast;
    logic                    swap_ok;
    logic signed [COEFW-1:0] coefs [N];
    logic                    coef_update;
    logic                    frame_err;
    logic                    err_clr;
`ifdef IIR_COEF_LOADER_READBACK_EN
    logic                    rb_req;
    logic        [COEFW-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;
`endif

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;
    int chg_cnt  = 0;
    int exp_set [N];
    int tx [8];
    logic signed [COEFW-1:0] prev [N];

    always #5 clk = ~clk;

    iir_coef_loader #(
        .COEFW     (COEFW),
        .ORDER     (2),
        .RST_COEF0 (1 << 16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .swap_ok       (swap_ok),
        .coefs         (coefs),
        .coef_update   (coef_update),
        .frame_err     (frame_err),
`ifdef IIR_COEF_LOADER_READBACK_EN
        .rb_req        (rb_req),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
`endif
        .err_clr       (err_clr)
    );

    always @(posedge clk) if (coef_update) upd_cnt++;

    // counts cycles in which the coefficient array changed at all
    always @(negedge clk) begin
        logic d;
        d = 1'b0;
        for (int k = 0; k < N; k++) if (coefs[k] !== prev[k]) d = 1'b1;
        if (d) chg_cnt++;
        prev = coefs;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_coefs(input string tag);
        for (int k = 0; k < N; k++) chk($sformatf("%s[%0d]", tag, k), coefs[k], exp_set[k]);
    endtask

    task automatic send(input int d, input logic l);
        int n;
        s_tdata  = COEFW'(d);
        s_tvalid = 1'b1;
        s_tlast  = l;
        n = 0;
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $error("FAIL send_tready observed=0 expected=1");
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_tx(input int cnt);
        for (int k = 0; k < cnt; k++) send(tx[k], k == cnt - 1);
    endtask

    task automatic wait_update(input string tag, input int base);
        int n;
        n = 0;
        while (upd_cnt == base && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_upd_cnt"}, upd_cnt, base + 1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int c0;
        int u0;
        logic bad_rdy;
        logic bad_coef;
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        swap_ok  = 1'b0;
        err_clr  = 1'b0;
`ifdef IIR_COEF_LOADER_READBACK_EN
        rb_req   = 1'b0;
        m_tready = 1'b0;
`endif
        idle(3);
        exp_set = '{65536, 0, 0, 0, 0, 0};
        chk_coefs("reset");
        chk("reset_update", coef_update, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_tready", s_tready, 0);
`ifdef IIR_COEF_LOADER_READBACK_EN
        chk("reset_m_tvalid", m_tvalid, 0);
`endif
        rst = 1'b0;
        idle(2);
        chk("post_reset_tready", s_tready, 1);

        // basic load with swap permitted
        swap_ok = 1'b1;
        #1 c0 = chg_cnt;
        tx = '{100, 200, 300, -400, 500, -600, 0, 0};
        send_tx(6);
        wait_update("load_a", 0);
        exp_set = '{100, 200, 300, -400, 500, -600};
        chk_coefs("load_a");
        idle(3);
        #1 chk("load_a_single_change", chg_cnt - c0, 1);
        chk("load_a_update_once", upd_cnt, 1);
        @(negedge clk);

        // swap held off: backpressure, no coef change, stalled 7th word
        swap_ok = 1'b0;
        tx = '{-1, 2, -3, 4, -5, 6, 0, 0};
        send_tx(6);
        idle(2);
        s_tdata  = COEFW'(999);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        bad_rdy  = 1'b0;
        bad_coef = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (s_tready) bad_rdy = 1'b1;
            if (coefs[0] !== 100 || coefs[5] !== -600) bad_coef = 1'b1;
        end
        chk("wait_tready_low", bad_rdy, 0);
        chk("wait_coefs_held", bad_coef, 0);
        chk("wait_no_update", upd_cnt, 1);
        swap_ok  = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        chk("swap_first_cycle", coef_update, 1);
        exp_set = '{-1, 2, -3, 4, -5, 6};
        chk_coefs("load_b");
        idle(4);
        chk("word7_not_taken_err", frame_err, 0);
        chk("load_b_update_cnt", upd_cnt, 2);

        // short set, then a good set
        tx = '{11, 12, 13, 14, 0, 0, 0, 0};
        send_tx(4);
        idle(4);
        chk("short_frame_err", frame_err, 1);
        chk("short_no_update", upd_cnt, 2);
        chk_coefs("short_coefs");
        tx = '{100, 200, 300, -400, 500, -600, 0, 0};
        send_tx(6);
        wait_update("after_short", 2);
        exp_set = '{100, 200, 300, -400, 500, -600};
        chk_coefs("after_short");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_after_short", frame_err, 0);

        // long set: drained, no swap, then recovery
        tx = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_tx(8);
        idle(4);
        chk("long_frame_err", frame_err, 1);
        chk("long_no_update", upd_cnt, 3);
        chk("long_coef0", coefs[0], 100);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_after_long", frame_err, 0);
        tx = '{11, -22, 33, -44, 55, -66, 0, 0};
        send_tx(6);
        wait_update("after_long", 3);
        exp_set = '{11, -22, 33, -44, 55, -66};
        chk_coefs("after_long");
        chk("after_long_err", frame_err, 0);

        // error and err_clr in the same cycle: error wins
        send(5, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_beats_clr", frame_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("final_clr", frame_err, 0);

`ifdef IIR_COEF_LOADER_READBACK_EN
        begin
            int rx [N];
            logic rxl [N];
            int got;
            tx = '{100, 200, 300, -400, 500, -600, 0, 0};
            send_tx(6);
            wait_update("rb_pre", 4);
            u0 = upd_cnt;
            rb_req = 1'b1;
            @(negedge clk);
            rb_req = 1'b0;
            got = 0;
            bad_coef = 1'b0;
            fork
                begin
                    tx = '{7, -7, 70, -70, 700, -700, 0, 0};
                    send_tx(6);
                end
                begin
                    for (int c = 0; c < 80 && got < N; c++) begin
                        @(negedge clk);
                        m_tready = ~m_tready;
                        if (coefs[0] !== 100 || coefs[5] !== -600) bad_coef = 1'b1;
                        if (m_tvalid && m_tready) begin
                            rx[got]  = $signed(m_tdata);
                            rxl[got] = m_tlast;
                            got++;
                        end
                    end
                end
            join
            m_tready = 1'b0;
            chk("rb_word_count", got, N);
            chk("rb_swap_deferred", bad_coef, 0);
            for (int k = 0; k < N; k++) begin
                chk($sformatf("rb_data[%0d]", k), rx[k], exp_set[k]);
                chk($sformatf("rb_last[%0d]", k), rxl[k], k == N - 1);
            end
            wait_update("rb_post", u0);
            exp_set = '{7, -7, 70, -70, 700, -700};
            chk_coefs("rb_post");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
